cond_exec_ctrl: RTL

Multicycle main controller for the ARM-subset processor.
- Sequences fetch/decode/execute/writeback through a Moore FSM.
- Holds the NZCV flag register and evaluates the instruction's condition field via the existing condcheck block.
- Gates every architectural write (register, memory, PC, flags) with the latched condition result.
- Sits between the instruction register (Op/Funct/Rd/Cond) and the datapath mux selects and enables.

---
 rtl/cond_ctrl_pkg.sv | 101 ++++++++++
 rtl/cond_flag_reg.sv | 61 ++++++
 rtl/cond_exec_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cond_ctrl_pkg.sv
// cond_ctrl_pkg: shared types and constants for the multicycle ARM-subset
// main controller.
// Contents: FSM state encoding, condition codes, opcode classes, ALU
// commands, mux-select constants, and helpers for condition evaluation and
// ALU command decode.
// Optional feature macro used by the controller: COND_SKIP_CNT_EN.
package cond_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ARM condition evaluation against NZCV; NV never executes.
  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ge;
    n  = nzcv[3];
    z  = nzcv[2];
    c  = nzcv[1];
    v  = nzcv[0];
    ge = (n == v);
    case (cond)
      COND_EQ: condcheck = z;
      COND_NE: condcheck = ~z;
      COND_CS: condcheck = c;
      COND_CC: condcheck = ~c;
      COND_MI: condcheck = n;
      COND_PL: condcheck = ~n;
      COND_VS: condcheck = v;
      COND_VC: condcheck = ~v;
      COND_HI: condcheck = c & ~z;
      COND_LS: condcheck = ~(c & ~z);
      COND_GE: condcheck = ge;
      COND_LT: condcheck = ~ge;
      COND_GT: condcheck = ~z & ge;
      COND_LE: condcheck = ~(~z & ge);
      COND_AL: condcheck = 1'b1;
      default: condcheck = 1'b0;
    endcase
  endfunction

  // Data-processing command to ALU operation; unknown commands add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_flag_reg.sv
// cond_flag_reg: NZCV flag register plus latched condition result.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   latch_cond      1 in DECODE: capture condition result at this edge
//   exec_state      1 in EXECUTER/EXECUTEI: flag write allowed at this edge
//   Cond            instruction condition field
//   cmd, set_flags  Funct[4:1] and Funct[0] of the instruction
//   ALUFlags        NZCV produced by the ALU this cycle
//   Flags           current NZCV register
//   cond_ex         latched condition result gating architectural writes
//   cond_now        condition evaluated against current Flags
module cond_flag_reg
  import cond_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_cond,
  input  logic       exec_state,
  input  logic [3:0] Cond,
  input  logic [3:0] cmd,
  input  logic       set_flags,
  input  logic [3:0] ALUFlags,
  output logic [3:0] Flags,
  output logic       cond_ex,
  output logic       cond_now
);

  logic [3:0] flags_r;
  logic       cond_ex_r;
  logic       nz_we_s;
  logic       cv_we_s;

  // Condition evaluation and split N/Z vs C/V write enables; logical ops keep C,V.
  always_comb begin
    cond_now = condcheck(Cond, flags_r);
    nz_we_s  = exec_state & cond_ex_r & set_flags;
    cv_we_s  = nz_we_s & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
  end

  // Flag and condition-result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_r   <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (latch_cond) begin
        cond_ex_r <= cond_now;
      end
      if (nz_we_s) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end
      if (cv_we_s) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign Flags   = flags_r;
  assign cond_ex = cond_ex_r;

endmodule

// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: multicycle Moore main controller for the ARM subset with
// conditional execution. Sequences FETCH/DECODE/execute/writeback, drives the
// datapath mux selects, and gates every architectural write with the
// condition result latched at DECODE.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   Op, Funct, Rd, Cond        instruction fields from the IR
//   ALUFlags                   NZCV from the ALU
//   PCWrite, MemWrite,
//   RegWrite, IRWrite          write enables (forced 0 while reset is low)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB           datapath mux selects
//   ALUControl                 ALU operation
//   Flags                      current NZCV
//   skip_cnt                   annulled-instruction count (COND_SKIP_CNT_EN only)
// Optional feature macro: COND_SKIP_CNT_EN (adds SKIP_CNT_W and skip_cnt).
module cond_exec_ctrl
  import cond_ctrl_pkg::*;
`ifdef COND_SKIP_CNT_EN
#(
  parameter int SKIP_CNT_W = 16
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
`ifdef COND_SKIP_CNT_EN
  ,
  output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);

  state_t state_r;
  state_t next_s;
  logic   cond_ex_s;
  logic   cond_now_s;
  logic   pc_we_s, mem_we_s, reg_we_s, ir_we_s;
  logic   exec_state_s;

  assign exec_state_s = (state_r == S_EXECUTER) | (state_r == S_EXECUTEI);

  cond_flag_reg u_flags (
    .clk        (clk),
    .reset      (reset),
    .latch_cond (state_r == S_DECODE),
    .exec_state (exec_state_s),
    .Cond       (Cond),
    .cmd        (Funct[4:1]),
    .set_flags  (Funct[0]),
    .ALUFlags   (ALUFlags),
    .Flags      (Flags),
    .cond_ex    (cond_ex_s),
    .cond_now   (cond_now_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_s = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  next_s = S_MEMADR;
          OP_DP:   next_s = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next_s = S_BRANCH;
          default: next_s = S_FETCH;
        endcase
      end
      S_MEMADR:   next_s = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_s = S_MEMWB;
      S_EXECUTER: next_s = S_ALUWB;
      S_EXECUTEI: next_s = S_ALUWB;
      default:    next_s = S_FETCH;
    endcase
  end

  // Per-state output decode; writes after DECODE are gated by the latched condition.
  always_comb begin
    pc_we_s    = 1'b0;
    mem_we_s   = 1'b0;
    reg_we_s   = 1'b0;
    ir_we_s    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ALUControl = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        ir_we_s   = 1'b1;
        pc_we_s   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMRD:    AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_we_s  = cond_ex_s;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        mem_we_s = cond_ex_s;
      end
      S_EXECUTER: begin
        ALUSrcB    = SRCB_WD;
        ALUControl = alu_decode(Funct[4:1]);
      end
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(Funct[4:1]);
      end
      S_ALUWB: begin
        reg_we_s = cond_ex_s & (Rd != 4'd15);
        pc_we_s  = cond_ex_s & (Rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_we_s   = cond_ex_s;
      end
      default: begin
        pc_we_s = 1'b0;
      end
    endcase
  end

  // Reset low suppresses all writes even before the state register settles.
  assign PCWrite  = pc_we_s  & reset;
  assign MemWrite = mem_we_s & reset;
  assign RegWrite = reg_we_s & reset;
  assign IRWrite  = ir_we_s  & reset;

`ifdef COND_SKIP_CNT_EN
  logic [SKIP_CNT_W-1:0] skip_cnt_r;
  logic                  skip_inc_s;

  assign skip_inc_s = (state_r == S_DECODE) & ~cond_now_s & (Op != OP_NOP) & (skip_cnt_r != '1);

  // Saturating count of instructions annulled by their condition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      skip_cnt_r <= '0;
    end else if (skip_inc_s) begin
      skip_cnt_r <= skip_cnt_r + {{(SKIP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      skip_cnt_r <= skip_cnt_r;
    end
  end

  assign skip_cnt = skip_cnt_r;
`endif

endmodule
